// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the frame burst scheduler: FSM state encoding,
// counter widths and the line-burst length derivation.
package fifo_sched_pkg;

    // Width of the line index and of the input frame counter.
    localparam int LINE_CNT_W  = 11;
    localparam int FRAME_CNT_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMING    = 3'd1,
        ST_WAIT_SOF  = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_REQ       = 3'd4,
        ST_RUN       = 3'd5
    } sched_state_t;

    // Four pixels are packed per AXIS beat, so a line burst is width/4 beats.
    function automatic int line_words(input int pixels_h);
        return pixels_h / 4;
    endfunction

endpackage

// File: rtl/frame_burst_scheduler.sv
// Frame burst scheduler: waits FRAME_DELAY input frames, then issues one
// burst request per output line once the backward FIFO holds enough data.
// Input frame starts arriving mid-frame are flagged and resynchronise the
// line sequence once the burst in flight has finished.
//
// Handshake: burst_req is a valid that stays high, with burst_sof stable,
// until the datapath answers burst_ack (ready); the transfer happens in the
// cycle where both are high, and burst_req drops on the following edge.
module frame_burst_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int FAW               = 8,
    parameter int PIXELS_HORIZONTAL = 1280,
    parameter int PIXELS_VERTICAL   = 1024,
    parameter int FRAME_DELAY       = 2,
    parameter int FILL_THRESH       = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  enable,
    input  logic                  sof_in,
    input  logic [FAW:0]          fifo_cnt,
    input  logic                  burst_ack,
    input  logic                  line_done,
    output logic                  burst_req,
    output logic                  burst_sof,
    output logic [LINE_CNT_W-1:0] line_idx,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int LINE_WORDS = line_words(PIXELS_HORIZONTAL);

    // A geometry the datapath cannot serve keeps the scheduler from arming.
    localparam bit CFG_OK = (LINE_WORDS > 0) && (FRAME_DELAY >= 0) &&
                            (FRAME_DELAY <= 1024) && (PIXELS_VERTICAL > 0) &&
                            (PIXELS_VERTICAL <= 2048);

    localparam logic [FRAME_CNT_W-1:0] DELAY_V   = FRAME_CNT_W'(FRAME_DELAY);
    localparam logic [LINE_CNT_W-1:0]  LAST_LINE = LINE_CNT_W'(PIXELS_VERTICAL - 1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = FRAME_CNT_W'(1);
    localparam logic [LINE_CNT_W-1:0]  LINE_ONE  = LINE_CNT_W'(1);

    logic [1:0]             rst_pipe;
    logic                   active;
    sched_state_t           state;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   sof_pending;
    logic                   resync_pending;
    logic                   enable_q;
    logic                   run_enable;
    logic                   fill_ok;
    logic                   delay_reached;
    logic                   last_line;

    assign active        = ~rst_pipe[1];
    assign run_enable    = enable & CFG_OK;
    assign fill_ok       = (32'(fifo_cnt) >= 32'(FILL_THRESH));
    assign delay_reached = ((frame_cnt + FRAME_ONE) >= DELAY_V);
    assign last_line     = (line_idx == LAST_LINE);

    // Reset release is delayed by two ACLK edges before the FSM may move.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    // Scheduler FSM with its counters and registered outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state          <= ST_IDLE;
            burst_req      <= 1'b0;
            burst_sof      <= 1'b0;
            line_idx       <= '0;
            busy           <= 1'b0;
            frame_err      <= 1'b0;
            frame_cnt      <= '0;
            sof_pending    <= 1'b0;
            resync_pending <= 1'b0;
            enable_q       <= 1'b0;
        end else if (active) begin
            enable_q <= enable;
            if (enable && !enable_q) begin
                frame_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    resync_pending <= 1'b0;
                    if (run_enable) begin
                        frame_cnt <= '0;
                        if (DELAY_V == '0) begin
                            state <= ST_WAIT_SOF;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_ARMING;
                        end
                    end
                end
                ST_ARMING: begin
                    if (!run_enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (sof_in) begin
                        if (frame_cnt != '1) begin
                            frame_cnt <= frame_cnt + FRAME_ONE;
                        end
                        if (delay_reached) begin
                            state <= ST_WAIT_SOF;
                            busy  <= 1'b1;
                        end
                    end else if (DELAY_V == '0) begin
                        state <= ST_WAIT_SOF;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT_SOF: begin
                    if (!run_enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (sof_in) begin
                        state       <= ST_WAIT_DATA;
                        line_idx    <= '0;
                        sof_pending <= 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (!run_enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (sof_in) begin
                        // No burst in flight: restart the frame right away.
                        frame_err   <= 1'b1;
                        line_idx    <= '0;
                        sof_pending <= 1'b1;
                    end else if (fill_ok) begin
                        state     <= ST_REQ;
                        burst_req <= 1'b1;
                        burst_sof <= sof_pending;
                    end
                end
                ST_REQ: begin
                    if (sof_in) begin
                        frame_err      <= 1'b1;
                        resync_pending <= 1'b1;
                    end
                    if (burst_ack) begin
                        state       <= ST_RUN;
                        burst_req   <= 1'b0;
                        burst_sof   <= 1'b0;
                        sof_pending <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (line_done) begin
                        if (resync_pending || sof_in) begin
                            // A frame start together with the final line is legal.
                            if (sof_in && !last_line) begin
                                frame_err <= 1'b1;
                            end
                            state          <= ST_WAIT_DATA;
                            line_idx       <= '0;
                            sof_pending    <= 1'b1;
                            resync_pending <= 1'b0;
                        end else if (last_line) begin
                            state <= ST_WAIT_SOF;
                        end else begin
                            state    <= ST_WAIT_DATA;
                            line_idx <= line_idx + LINE_ONE;
                        end
                    end else if (sof_in) begin
                        frame_err      <= 1'b1;
                        resync_pending <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    burst_req <= 1'b0;
                    burst_sof <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_burst_scheduler.sv
// Directed bench for frame_burst_scheduler with a small geometry:
// 16 pixels per line, 3 lines per frame, two frames of delay, threshold 2.
module tb_frame_burst_scheduler;

    localparam int FAW = 3;

    logic        ACLK;
    logic        ARESET;
    logic        enable;
    logic        sof_in;
    logic [FAW:0] fifo_cnt;
    logic        burst_ack;
    logic        line_done;
    logic        burst_req;
    logic        burst_sof;
    logic [10:0] line_idx;
    logic        busy;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    frame_burst_scheduler #(
        .FAW               (FAW),
        .PIXELS_HORIZONTAL (16),
        .PIXELS_VERTICAL   (3),
        .FRAME_DELAY       (2),
        .FILL_THRESH       (2)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .enable    (enable),
        .sof_in    (sof_in),
        .fifo_cnt  (fifo_cnt),
        .burst_ack (burst_ack),
        .line_done (line_done),
        .burst_req (burst_req),
        .burst_sof (burst_sof),
        .line_idx  (line_idx),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Clock and watchdog
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver and checker tasks; inputs change and outputs are sampled at negedge
    task automatic cyc();
        @(negedge ACLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_sof();
        sof_in = 1'b1;
        cyc();
        sof_in = 1'b0;
    endtask

    task automatic wait_req(input int max_cycles);
        int n = 0;
        while (burst_req !== 1'b1 && n < max_cycles) begin
            cyc();
            n++;
        end
        chk("req_timeout", 32'(burst_req), 32'd1);
    endtask

    task automatic ack_burst();
        burst_ack = 1'b1;
        cyc();
        burst_ack = 1'b0;
        chk("req_drop_after_ack", 32'(burst_req), 32'd0);
    endtask

    task automatic end_line();
        line_done = 1'b1;
        cyc();
        line_done = 1'b0;
    endtask

    task automatic do_line(input logic [10:0] exp_line, input logic exp_sof);
        wait_req(20);
        chk("line_idx", 32'(line_idx), 32'(exp_line));
        chk("burst_sof", 32'(burst_sof), 32'(exp_sof));
        ack_burst();
        end_line();
    endtask

    // Directed stimulus sequence
    initial begin
        ARESET    = 1'b1;
        enable    = 1'b0;
        sof_in    = 1'b0;
        fifo_cnt  = 4'd4;
        burst_ack = 1'b0;
        line_done = 1'b0;
        cyc();
        cyc();
        chk("rst_burst_req", 32'(burst_req), 32'd0);
        chk("rst_burst_sof", 32'(burst_sof), 32'd0);
        chk("rst_line_idx", 32'(line_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        ARESET = 1'b0;
        cyc();
        cyc();
        cyc();

        // Two frames of delay, then three line bursts
        enable = 1'b1;
        cyc();
        chk("arming_busy", 32'(busy), 32'd0);
        pulse_sof();
        chk("arm1_busy", 32'(busy), 32'd0);
        chk("arm1_req", 32'(burst_req), 32'd0);
        cyc();
        pulse_sof();
        chk("arm2_busy", 32'(busy), 32'd1);
        chk("arm2_req", 32'(burst_req), 32'd0);
        cyc();
        chk("waitsof_req", 32'(burst_req), 32'd0);
        pulse_sof();
        chk("latency_1cyc_req", 32'(burst_req), 32'd0);
        cyc();
        chk("latency_2cyc_req", 32'(burst_req), 32'd1);
        do_line(11'd0, 1'b1);
        do_line(11'd1, 1'b0);
        do_line(11'd2, 1'b0);
        chk("frame_end_req", 32'(burst_req), 32'd0);
        chk("frame_end_busy", 32'(busy), 32'd1);
        end_line();
        cyc();
        cyc();
        chk("stray_done_line_idx", 32'(line_idx), 32'd2);
        chk("waitsof_idle_req", 32'(burst_req), 32'd0);
        chk("no_frame_err", 32'(frame_err), 32'd0);

        // Below-threshold FIFO holds the request back
        fifo_cnt = 4'd1;
        pulse_sof();
        for (int i = 0; i < 20; i++) begin
            chk("below_thresh_req", 32'(burst_req), 32'd0);
            cyc();
        end
        fifo_cnt = 4'd2;
        chk("thresh_same_cycle_req", 32'(burst_req), 32'd0);
        cyc();
        chk("thresh_req", 32'(burst_req), 32'd1);
        chk("thresh_sof", 32'(burst_sof), 32'd1);
        chk("thresh_line", 32'(line_idx), 32'd0);

        // Withheld acknowledge keeps the request stable, single RUN entry
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_req", 32'(burst_req), 32'd1);
            chk("hold_sof", 32'(burst_sof), 32'd1);
        end
        ack_burst();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("run_no_rereq", 32'(burst_req), 32'd0);
            chk("run_busy", 32'(busy), 32'd1);
        end
        end_line();
        fifo_cnt = 4'd4;

        // Final line_done together with sof_in is a legal frame start
        do_line(11'd1, 1'b0);
        wait_req(20);
        chk("last_line_idx", 32'(line_idx), 32'd2);
        ack_burst();
        sof_in    = 1'b1;
        line_done = 1'b1;
        cyc();
        sof_in    = 1'b0;
        line_done = 1'b0;
        chk("coincident_frame_err", 32'(frame_err), 32'd0);
        wait_req(20);
        chk("coincident_line", 32'(line_idx), 32'd0);
        chk("coincident_sof", 32'(burst_sof), 32'd1);
        chk("coincident_frame_err2", 32'(frame_err), 32'd0);

        // sof_in during RUN of line 1 flags an error and resyncs to line 0
        ack_burst();
        end_line();
        wait_req(20);
        chk("resync_pre_line", 32'(line_idx), 32'd1);
        chk("resync_pre_sof", 32'(burst_sof), 32'd0);
        ack_burst();
        pulse_sof();
        chk("mid_frame_err", 32'(frame_err), 32'd1);
        chk("mid_frame_req", 32'(burst_req), 32'd0);
        end_line();
        wait_req(20);
        chk("resync_line", 32'(line_idx), 32'd0);
        chk("resync_sof", 32'(burst_sof), 32'd1);
        chk("resync_err_sticky", 32'(frame_err), 32'd1);

        // Asynchronous reset in RUN, then frame delay counts from zero again
        ack_burst();
        ARESET = 1'b1;
        #1;
        chk("async_burst_req", 32'(burst_req), 32'd0);
        chk("async_burst_sof", 32'(burst_sof), 32'd0);
        chk("async_line_idx", 32'(line_idx), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_frame_err", 32'(frame_err), 32'd0);
        cyc();
        cyc();
        ARESET = 1'b0;
        cyc();
        cyc();
        cyc();
        cyc();
        chk("rearm_busy", 32'(busy), 32'd0);
        pulse_sof();
        cyc();
        chk("rearm1_busy", 32'(busy), 32'd0);
        pulse_sof();
        cyc();
        chk("rearm2_busy", 32'(busy), 32'd1);
        chk("rearm2_req", 32'(burst_req), 32'd0);
        pulse_sof();
        cyc();
        chk("rearm_req", 32'(burst_req), 32'd1);
        chk("rearm_line", 32'(line_idx), 32'd0);
        chk("rearm_sof", 32'(burst_sof), 32'd1);

        // enable=0 waits for the burst in flight, then returns to IDLE
        enable = 1'b0;
        cyc();
        chk("disable_req_held", 32'(burst_req), 32'd1);
        ack_burst();
        end_line();
        chk("disable_wait_data_busy", 32'(busy), 32'd1);
        cyc();
        chk("disable_idle_busy", 32'(busy), 32'd0);
        chk("disable_idle_req", 32'(burst_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_burst_scheduler.md
FRAME_BURST_SCHEDULER -- requirements
Module: frame_burst_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all ports SHALL be as listed below (parameters first, then ports, clock and reset first).
REQ-002 Parameter FAW, default 8: FIFO address width; the fill count is FAW+1 bits.
REQ-003 Parameter PIXELS_HORIZONTAL, default 1280: pixels per line; LINE_WORDS = PIXELS_HORIZONTAL/4 AXIS beats per line burst.
REQ-004 Parameter PIXELS_VERTICAL, default 1024: lines per frame.
REQ-005 Parameter FRAME_DELAY, default 2, max 1024: input frame starts counted before the first output frame.
REQ-006 Parameter FILL_THRESH, default 64: minimum FIFO fill required before a line burst is issued.
REQ-007 Ports:
- ACLK  in  1  clock
- ARESET  in  1  async active-high reset
- enable  in  1  scheduler run enable
- sof_in  in  1  one-cycle pulse, input frame start (S_AXIS user beat accepted)
- fifo_cnt  in  FAW+1  backward FIFO fill level
- burst_ack  in  1  datapath accepted burst request
- line_done  in  1  one-cycle pulse, last beat of burst accepted (tlast & tready)
- burst_req  out  1  line burst request, held until acknowledged
- burst_sof  out  1  qualifies burst_req: first line of frame (drives M_AXIS_USER)
- line_idx  out  11  current line number, 0..PIXELS_VERTICAL-1
- busy  out  1  state not IDLE/ARMING
- frame_err  out  1  sticky: sof_in arrived mid-frame

Function
REQ-008 States SHALL be IDLE, ARMING, WAIT_SOF, WAIT_DATA, REQ, RUN.
REQ-009 IDLE -> ARMING when enable=1; frame counter cleared on entry to ARMING.
REQ-010 ARMING: each sof_in increments a saturating frame counter; -> WAIT_SOF when the counter reaches FRAME_DELAY. FRAME_DELAY=0 SHALL go directly to WAIT_SOF.
REQ-011 WAIT_SOF -> WAIT_DATA on sof_in; line_idx <= 0; sof_pending <= 1.
REQ-012 WAIT_DATA -> REQ when fifo_cnt >= FILL_THRESH; no request is raised below threshold.
REQ-013 REQ: burst_req=1 and burst_sof=sof_pending are held stable until burst_ack; on burst_ack -> RUN and sof_pending <= 0; req/ack in the same cycle completes the handshake.
REQ-014 RUN -> on line_done: if line_idx == PIXELS_VERTICAL-1, -> WAIT_SOF; otherwise line_idx increments and -> WAIT_DATA.
REQ-015 Minimum latency: sof_in to burst_req is 2 cycles when fifo_cnt is already >= FILL_THRESH.
REQ-016 sof_in in WAIT_DATA, REQ or RUN SHALL set frame_err; the current burst completes, then line_idx <= 0, sof_pending <= 1, -> WAIT_DATA (resync, no WAIT_SOF).
REQ-017 sof_in in the same cycle as the final line_done SHALL be treated as a legal frame start (-> WAIT_DATA, line_idx 0, no frame_err).
REQ-018 enable=0 SHALL take effect only from IDLE, ARMING, WAIT_SOF or WAIT_DATA (-> IDLE); REQ and RUN always complete first.
REQ-019 line_done outside RUN SHALL be ignored; burst_ack outside REQ SHALL be ignored.
REQ-020 frame_err SHALL clear only on reset or on the enable 0->1 transition.

Reset
REQ-021 ARESET SHALL immediately force state IDLE, burst_req=0, burst_sof=0, line_idx=0, busy=0, frame_err=0, frame counter 0, sof_pending 0.
REQ-022 Release of ARESET SHALL be synchronised internally (two-flop); the first state change occurs no earlier than the second ACLK edge after deassertion.

Structure
REQ-023 A shared package fifo_sched_pkg SHALL hold the state enum, the LINE_WORDS derivation and the 11-bit line/frame counter width constants.
REQ-024 The block SHALL be a single module with no sub-module; counters and FSM reside in one file.

Verification (PIXELS_HORIZONTAL=16, PIXELS_VERTICAL=3, FRAME_DELAY=2, FILL_THRESH=2, FAW=3)
REQ-025 enable=1, three sof_in pulses, fifo_cnt=4, immediate ack/line_done -> no burst_req after the first two; three bursts after the third, line_idx 0,1,2; burst_sof only on line 0.
REQ-026 fifo_cnt=1 in WAIT_DATA for 20 cycles, then 2 -> burst_req stays low for 20 cycles and rises the cycle after fifo_cnt=2.
REQ-027 burst_ack withheld 10 cycles -> burst_req and burst_sof remain stable for all 10 cycles; exactly one RUN entry.
REQ-028 sof_in during RUN of line 1 -> frame_err=1; after line_done, the next burst has line_idx=0 and burst_sof=1.
REQ-029 ARESET pulsed during RUN -> all outputs 0 in the same cycle; after release and enable, the FRAME_DELAY count restarts from 0.
REQ-030 Final line_done coincident with sof_in -> frame_err stays 0; the next burst has line_idx=0 and burst_sof=1.
